// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: synchronizes the RX pin, samples each bit at its mid-point
// and presents good bytes with a one-cycle strobe; bad stop bits raise a one-cycle error.
module uart_byte_receiver #(
    parameter int CLKS_PER_BIT = 217,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Frame_Error,
    output logic       o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK,
        CLEANUP
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       clk_cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // Synchronizer presets to the idle level so reset never looks like a start bit.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_Rx_Serial};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            o_Rx_DV       <= 1'b0;
            o_Rx_Byte     <= 8'h00;
            o_Frame_Error <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            o_Rx_DV       <= 1'b0;
            o_Frame_Error <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    o_Busy  <= 1'b0;
                    if (!rx_s) begin
                        state  <= START;
                        o_Busy <= 1'b1;
                    end
                end

                // A low that has vanished by mid-bit is treated as noise.
                START: begin
                    if (clk_cnt == HALF) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state  <= IDLE;
                            o_Busy <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt        <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            o_Rx_Byte <= shift;
                            o_Rx_DV   <= 1'b1;
                            state     <= CLEANUP;
                        end else begin
                            o_Frame_Error <= 1'b1;
                            state         <= BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                // Held-low line: one error pulse, then wait for idle before re-arming.
                BREAK: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= CLEANUP;
                    end
                end

                CLEANUP: begin
                    clk_cnt <= '0;
                    state   <= IDLE;
                    o_Busy  <= 1'b0;
                end

                default: begin
                    clk_cnt <= '0;
                    state   <= IDLE;
                    o_Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Self-checking bench for uart_byte_receiver: directed frame table, glitch/reset/phase
// sequences, then random frames checked against a frame-level expectation model.
module tb_uart_byte_receiver;

    localparam int CPB     = 8;
    localparam int SYNC    = 2;
    localparam int HALF    = (CPB - 1) / 2;
    localparam int LATENCY = SYNC + 1 + HALF + 9 * CPB + 1;

    logic       i_Clock = 1'b0;
    logic       i_Reset;
    logic       i_Rx_Serial;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Frame_Error;
    logic       o_Busy;

    uart_byte_receiver #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYNC)
    ) dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Rx_Serial  (i_Rx_Serial),
        .o_Rx_DV      (o_Rx_DV),
        .o_Rx_Byte    (o_Rx_Byte),
        .o_Frame_Error(o_Frame_Error),
        .o_Busy       (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    int vectors_applied = 0;
    int miscompares     = 0;

    int cyc = 0;
    always @(posedge i_Clock) cyc <= cyc + 1;

    // Event log of everything the DUT reports, sampled mid-cycle.
    int         dv_total      = 0;
    int         fe_total      = 0;
    int         overlap_total = 0;
    int         busy_total    = 0;
    logic [7:0] dv_log[0:255];
    int         dv_cyc_log[0:255];

    always @(negedge i_Clock) begin
        if (o_Rx_DV) begin
            dv_log[dv_total[7:0]]     <= o_Rx_Byte;
            dv_cyc_log[dv_total[7:0]] <= cyc;
            dv_total                  <= dv_total + 1;
        end
        if (o_Frame_Error) fe_total <= fe_total + 1;
        if (o_Rx_DV && o_Frame_Error) overlap_total <= overlap_total + 1;
        if (o_Busy) busy_total <= busy_total + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         low_hold;
        int         gap;
        int         exp_dv;
        int         exp_fe;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] model_last;
    int         start_cyc;
    int         dv0, fe0, ov0, busy0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors_applied++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, actual, actual, expected, expected, cyc);
        end
    endtask

    task automatic checkLatency(input int lat);
        vectors_applied++;
        if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
            miscompares++;
            $display("[TB] FAIL dv_latency: got %0d cycles, expected %0d +/-1", lat, LATENCY);
        end
    endtask

    task automatic driveBits(input logic v, input int n);
        i_Rx_Serial = v;
        repeat (n) begin
            @(posedge i_Clock);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                 input int low_hold, input int gap);
        start_cyc = cyc;
        driveBits(1'b0, CPB);
        for (int i = 0; i < 8; i++) driveBits(data[i], CPB);
        driveBits(stop_bit, CPB);
        if (!stop_bit) driveBits(1'b0, low_hold);
        driveBits(1'b1, gap);
    endtask

    task automatic snapshot();
        dv0   = dv_total;
        fe0   = fe_total;
        ov0   = overlap_total;
        busy0 = busy_total;
    endtask

    task automatic runFrame(input vec_t v);
        int idx;
        snapshot();
        applyStimulus(v.data, v.stop_bit, v.low_hold, v.gap);
        idx = dv_total - 1;
        checkOutput("dv_count", dv_total - dv0, v.exp_dv);
        if (v.exp_dv > 0) checkOutput("dv_byte", dv_log[idx[7:0]], v.exp_byte);
        checkOutput("fe_count", fe_total - fe0, v.exp_fe);
        checkOutput("dv_fe_overlap", overlap_total - ov0, 0);
        checkOutput("held_byte", o_Rx_Byte, v.exp_byte);
        if (v.gap >= 6) checkOutput("busy_idle", o_Busy, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_dv"}, o_Rx_DV, 0);
        checkOutput({tag, "_byte"}, o_Rx_Byte, 0);
        checkOutput({tag, "_fe"}, o_Frame_Error, 0);
        checkOutput({tag, "_busy"}, o_Busy, 0);
    endtask

    initial begin
        vec_t v;
        int   idx;

        vecs[0] = '{8'h55, 1'b1, 0, 8, 1, 0, 8'h55};
        vecs[1] = '{8'h01, 1'b1, 0, 0, 1, 0, 8'h01};
        vecs[2] = '{8'h80, 1'b1, 0, 0, 1, 0, 8'h80};
        vecs[3] = '{8'hFF, 1'b1, 0, 8, 1, 0, 8'hFF};
        vecs[4] = '{8'hA5, 1'b0, 40, 8, 0, 1, 8'hFF};
        vecs[5] = '{8'h3C, 1'b1, 0, 8, 1, 0, 8'h3C};

        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        repeat (3) @(posedge i_Clock);
        #1;
        checkResetValues("reset");
        i_Reset = 1'b0;
        driveBits(1'b1, 4);

        for (int i = 0; i < 6; i++) runFrame(vecs[i]);
        model_last = 8'h3C;

        // Short low on an idle line: busy blips, nothing is reported.
        snapshot();
        driveBits(1'b0, 3);
        driveBits(1'b1, 20);
        checkOutput("glitch_busy_seen", (busy_total > busy0) ? 1 : 0, 1);
        checkOutput("glitch_dv", dv_total - dv0, 0);
        checkOutput("glitch_fe", fe_total - fe0, 0);
        checkOutput("glitch_byte", o_Rx_Byte, model_last);
        checkOutput("glitch_busy_idle", o_Busy, 0);

        // Reset lands inside data bit 4 of 0xC3; the transmitter goes idle with it.
        snapshot();
        driveBits(1'b0, CPB);
        for (int i = 0; i < 4; i++) driveBits(8'hC3 >> i, CPB);
        driveBits(1'b0, 3);
        i_Reset     = 1'b1;
        i_Rx_Serial = 1'b1;
        @(posedge i_Clock);
        #1;
        checkResetValues("midreset");
        i_Reset = 1'b0;
        driveBits(1'b1, 100);
        checkOutput("aborted_dv", dv_total - dv0, 0);
        checkOutput("aborted_fe", fe_total - fe0, 0);
        v = '{8'h12, 1'b1, 0, 8, 1, 0, 8'h12};
        runFrame(v);
        model_last = 8'h12;

        // Phase sweep of the start edge against the byte stream.
        for (int p = 0; p < 8; p++) begin
            driveBits(1'b1, p);
            v = '{8'h6E, 1'b1, 0, 8, 1, 0, 8'h6E};
            runFrame(v);
            idx = dv_total - 1;
            if (dv_total > dv0) checkLatency(dv_cyc_log[idx[7:0]] - start_cyc);
        end
        model_last = 8'h6E;

        // Random frames against the frame-level expectation model.
        for (int n = 0; n < 40; n++) begin
            v.data     = 8'($urandom);
            v.stop_bit = ($urandom_range(0, 3) != 0);
            if (v.stop_bit) begin
                v.low_hold = 0;
                v.gap      = $urandom_range(0, 10);
                model_last = v.data;
            end else begin
                v.low_hold = $urandom_range(0, 30);
                v.gap      = $urandom_range(6, 12);
            end
            v.exp_dv   = v.stop_bit ? 1 : 0;
            v.exp_fe   = v.stop_bit ? 0 : 1;
            v.exp_byte = model_last;
            runFrame(v);
        end

        driveBits(1'b1, 20);
        checkOutput("final_busy", o_Busy, 0);
        checkOutput("final_overlap_total", overlap_total, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
